// File: rtl/accel_uart_pkg.sv
// rtl/accel_uart_pkg.sv - shared constants and types for the accel UART host link
// Purpose: command codes, packet/frame geometry and the response-transmitter
//          FSM state type shared by the UART link blocks.
// Ports:   none (package).
package accel_uart_pkg;

   // Host command codes carried in the first packet byte
   localparam logic [7:0] CMD_CSR_WR   = 8'h00;
   localparam logic [7:0] CMD_BUF_WR_A = 8'h20;
   localparam logic [7:0] CMD_BUF_WR_B = 8'h30;
   localparam logic [7:0] CMD_START    = 8'h50;
   localparam logic [7:0] CMD_STATUS   = 8'h70;

   // Packet: cmd, addr[7:0], addr[15:8], data byte 0..3
   localparam int PKT_BYTES = 7;

   // 8N1 frame
   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam int   DATA_BITS  = 8;
   localparam int   FRAME_BITS = DATA_BITS + 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_GAP,
      ST_DONE
   } resp_state_t;

endpackage

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 byte serializer with gapless back-to-back framing
// Purpose: shifts one byte out as start bit, 8 data bits LSB first, stop bit,
//          each bit held CLKS_PER_BIT cycles.
// Ports:
//   i_clk         system clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_byte_valid  byte offered
//   i_byte_data   byte to send
//   o_byte_ready  high when idle and in the last cycle of the stop bit
//   o_tx          registered serial output, idle high
module uart_byte_tx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_byte_valid,
   input  logic [7:0] i_byte_data,
   output logic       o_byte_ready,
   output logic       o_tx
);
   import accel_uart_pkg::*;

   localparam int              BW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0]   BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]      BIT_LAST  = 4'(DATA_BITS);      // last data bit index
   localparam logic [3:0]      BIT_STOP  = 4'(DATA_BITS + 1);  // stop bit index

   // r_bit_cnt: 0 = start bit, 1..8 = data bits, 9 = stop bit
   logic [BW-1:0] r_baud_cnt;
   logic [3:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   logic          r_busy;
   logic          r_tx;
   logic          w_baud_last;
   logic          w_stop_last;

   assign w_baud_last  = (r_baud_cnt == BAUD_LAST);
   assign w_stop_last  = r_busy && (r_bit_cnt == BIT_STOP) && w_baud_last;
   // Ready in the final stop cycle lets the next start bit follow with no idle cycle
   assign o_byte_ready = !r_busy || w_stop_last;
   assign o_tx         = r_tx;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_baud_cnt <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_busy     <= 1'b0;
         r_tx       <= STOP_BIT;
      end else if (i_byte_valid && o_byte_ready) begin
         r_shift    <= i_byte_data;
         r_baud_cnt <= '0;
         r_bit_cnt  <= '0;
         r_busy     <= 1'b1;
         r_tx       <= START_BIT;
      end else if (r_busy) begin
         if (w_baud_last) begin
            r_baud_cnt <= '0;
            if (r_bit_cnt == BIT_STOP) begin
               r_busy <= 1'b0;
            end else begin
               r_bit_cnt <= r_bit_cnt + 4'd1;
               if (r_bit_cnt == BIT_LAST) begin
                  r_tx <= STOP_BIT;
               end else begin
                  r_tx    <= r_shift[0];
                  r_shift <= {1'b0, r_shift[7:1]};
               end
            end
         end else begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_resp_tx.sv
// rtl/uart_resp_tx.sv - 7-byte response packet transmitter for the UART host link
// Purpose: accepts {cmd, addr, data} on a valid/ready handshake and sends it as
//          cmd, addr lo, addr hi, data byte 0..3 in 8N1 frames, followed by
//          GAP_BITS idle bit-times.
// Ports:
//   i_clk         system clock, rising edge
//   i_rst         asynchronous active-high reset
//   i_resp_valid  response available
//   o_resp_ready  registered; block can accept a response
//   i_resp_cmd    command byte, sent first
//   i_resp_addr   address, low byte first
//   i_resp_data   payload, byte 0 first
//   o_uart_tx     serial line, idle high
//   o_tx_busy     high from acceptance until packet completion
//   o_pkt_done    one-cycle pulse in the final cycle of the packet
module uart_resp_tx #(
   parameter int CLK_HZ   = 50_000_000,
   parameter int BAUD     = 115_200,
   parameter int GAP_BITS = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_resp_valid,
   output logic        o_resp_ready,
   input  logic [7:0]  i_resp_cmd,
   input  logic [15:0] i_resp_addr,
   input  logic [31:0] i_resp_data,
   output logic        o_uart_tx,
   output logic        o_tx_busy,
   output logic        o_pkt_done
);
   import accel_uart_pkg::*;

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_cfg
         $error("uart_resp_tx: CLK_HZ/BAUD must be at least 2");
      end
   endgenerate

   // The tail timer spans the last byte plus the gap so that the single DONE
   // cycle lands on the final high cycle of the packet, even with no gap.
   localparam int            TAIL_CYCLES = (FRAME_BITS + GAP_BITS) * CLKS_PER_BIT;
   localparam int            TW          = $clog2(TAIL_CYCLES);
   localparam logic [TW-1:0] TAIL_LOAD   = TW'(TAIL_CYCLES - 2);
   localparam logic [2:0]    LAST_BYTE   = 3'(PKT_BYTES - 1);

   resp_state_t   r_state;
   resp_state_t   w_state_nxt;
   logic [47:0]   r_shift;      // bytes 1..6; byte 0 (cmd) goes straight out at accept
   logic [2:0]    r_byte_cnt;   // index of the byte currently in the serializer
   logic [TW-1:0] r_tail_cnt;
   logic          r_ready;
   logic          r_busy;
   logic          r_done;

   logic          w_xfer;
   logic          w_handoff;
   logic          w_byte_valid;
   logic [7:0]    w_byte_data;
   logic          w_byte_ready;

   assign w_xfer = i_resp_valid && r_ready;

   always_comb begin
      w_state_nxt  = r_state;
      w_byte_valid = 1'b0;
      w_byte_data  = i_resp_cmd;
      w_handoff    = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            // Serializer is idle or in its last stop cycle here, so it takes cmd now
            if (w_xfer) begin
               w_state_nxt  = ST_SEND;
               w_byte_valid = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (r_byte_cnt != LAST_BYTE) begin
               w_byte_data = r_shift[7:0];
               if (w_byte_ready) begin
                  w_byte_valid = 1'b1;
                  w_handoff    = 1'b1;
               end
            end else if (r_tail_cnt == '0) begin
               w_state_nxt = ST_DONE;
            end else if (w_byte_ready) begin
               w_state_nxt = ST_GAP;
            end
         end
         ST_GAP: begin
            if (r_tail_cnt == '0) begin
               w_state_nxt = ST_DONE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_shift    <= '0;
         r_byte_cnt <= '0;
         r_tail_cnt <= '0;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_DONE);
         r_busy  <= (w_state_nxt == ST_SEND) || (w_state_nxt == ST_GAP);
         r_done  <= (w_state_nxt == ST_DONE);
         if (w_xfer) begin
            r_shift    <= {i_resp_data, i_resp_addr};
            r_byte_cnt <= '0;
         end else if (w_handoff) begin
            r_shift    <= {8'h00, r_shift[47:8]};
            r_byte_cnt <= r_byte_cnt + 3'd1;
            if (r_byte_cnt == LAST_BYTE - 3'd1) begin
               r_tail_cnt <= TAIL_LOAD;
            end
         end else if (r_tail_cnt != '0) begin
            r_tail_cnt <= r_tail_cnt - 1'b1;
         end
      end
   end

   assign o_resp_ready = r_ready;
   assign o_tx_busy    = r_busy;
   assign o_pkt_done   = r_done;

   uart_byte_tx #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_byte_tx (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_byte_valid (w_byte_valid),
      .i_byte_data  (w_byte_data),
      .o_byte_ready (w_byte_ready),
      .o_tx         (o_uart_tx)
   );

endmodule

// File: tb/tb_uart_resp_tx.sv
// tb/tb_uart_resp_tx.sv - directed self-checking bench for uart_resp_tx
module tb_uart_resp_tx;

   logic        clk;
   logic [2:0]  rst;
   logic [2:0]  valid;
   logic [2:0]  ready;
   logic [2:0]  txl;
   logic [2:0]  busy;
   logic [2:0]  done;
   logic [7:0]  cmd  [3];
   logic [15:0] addr [3];
   logic [31:0] data [3];

   int n_cmp  = 0;
   int n_fail = 0;

   int got_b[$];
   int got_s[$];
   int done_q[$];
   int bad_edge;
   int bad_stop;
   int busy_lo;

   int exp_st[$] = '{'h70, 'h00, 'h00, 'h01, 'h00, 'h00, 'h00};
   int exp_a5[$] = '{'hA5, 'h3C, 'h5A, 'hEF, 'hBE, 'hAD, 'hDE};
   int exp_bb[$] = '{'h70, 'h01, 'h00, 'h44, 'h33, 'h22, 'h11,
                     'h00, 'h08, 'h00, 'h08, 'h00, 'h00, 'h00};
   int exp_cf[$] = '{'h50, 'h34, 'h12, 'h0D, 'hF0, 'hFE, 'hCA};
   int exp_sm[$] = '{'h30, 'h02, 'h01, 'h06, 'h05, 'h04, 'h03,
                     'h20, 'hFF, 'hFF, 'h01, 'h00, 'h00, 'h80};

   // idx 0: defaults (434 clocks/bit, gap 2); idx 1: 10 clocks/bit, gap 2; idx 2: 8 clocks/bit, gap 0
   uart_resp_tx #(.CLK_HZ(50_000_000), .BAUD(115_200), .GAP_BITS(2)) u_def (
      .i_clk(clk), .i_rst(rst[0]), .i_resp_valid(valid[0]), .o_resp_ready(ready[0]),
      .i_resp_cmd(cmd[0]), .i_resp_addr(addr[0]), .i_resp_data(data[0]),
      .o_uart_tx(txl[0]), .o_tx_busy(busy[0]), .o_pkt_done(done[0]));

   uart_resp_tx #(.CLK_HZ(1000), .BAUD(100), .GAP_BITS(2)) u_mid (
      .i_clk(clk), .i_rst(rst[1]), .i_resp_valid(valid[1]), .o_resp_ready(ready[1]),
      .i_resp_cmd(cmd[1]), .i_resp_addr(addr[1]), .i_resp_data(data[1]),
      .o_uart_tx(txl[1]), .o_tx_busy(busy[1]), .o_pkt_done(done[1]));

   uart_resp_tx #(.CLK_HZ(8), .BAUD(1), .GAP_BITS(0)) u_sml (
      .i_clk(clk), .i_rst(rst[2]), .i_resp_valid(valid[2]), .o_resp_ready(ready[2]),
      .i_resp_cmd(cmd[2]), .i_resp_addr(addr[2]), .i_resp_data(data[2]),
      .o_uart_tx(txl[2]), .o_tx_busy(busy[2]), .o_pkt_done(done[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int qat(input int q[$], input int i);
      if (i < q.size()) return q[i];
      else return -1;
   endfunction

   task automatic chk_bytes(input string tag, input int exp[$]);
      chk({tag, "_nbytes"}, got_b.size(), exp.size());
      for (int k = 0; k < exp.size(); k++)
         chk($sformatf("%s_byte%0d", tag, k), qat(got_b, k), exp[k]);
   endtask

   // Called on a negedge; returns on the negedge of cycle 1 after the accept edge.
   task automatic start_pkt(input int idx, input logic [7:0] c, input logic [15:0] a,
                            input logic [31:0] d);
      int t;
      t = 0;
      cmd[idx] = c; addr[idx] = a; data[idx] = d; valid[idx] = 1'b1;
      while (ready[idx] !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("ready_before_accept", ready[idx], 1);
      @(negedge clk);
   endtask

   // Samples the line for ncyc negedges (n = 1 is the current one), decoding
   // frames with a mid-bit receiver and logging starts, pkt_done and busy.
   task automatic capture(input int idx, input int cpb, input int ncyc, input int drop_n,
                          input int chg_n, input logic [7:0] c2, input logic [15:0] a2,
                          input logic [31:0] d2);
      bit         rx_on;
      int         rx_start;
      int         off;
      logic [7:0] rx_byte;
      logic       line;
      logic       prev;
      got_b.delete(); got_s.delete(); done_q.delete();
      bad_edge = 0; bad_stop = 0; busy_lo = -1;
      rx_on = 0; rx_start = 0; rx_byte = 8'h00; prev = 1'b1;
      for (int n = 1; n <= ncyc; n++) begin
         if (n > 1) @(negedge clk);
         line = txl[idx];
         if (done[idx] === 1'b1) done_q.push_back(n);
         if (busy[idx] !== 1'b1 && busy_lo < 0) busy_lo = n;
         if (line !== prev) begin
            if (!rx_on && line === 1'b0) begin
               rx_on = 1; rx_start = n; rx_byte = 8'h00;
            end else if (!rx_on || ((n - rx_start) % cpb) != 0) begin
               bad_edge++;
            end
         end
         if (rx_on) begin
            off = n - rx_start;
            if ((off % cpb) == cpb / 2) begin
               if (off / cpb == 0) begin
                  if (line !== 1'b0) bad_stop++;
               end else if (off / cpb <= 8) begin
                  rx_byte = {line, rx_byte[7:1]};
               end else begin
                  if (line !== 1'b1) bad_stop++;
                  got_b.push_back(int'(rx_byte));
                  got_s.push_back(rx_start);
                  rx_on = 0;
               end
            end
         end
         if (n == drop_n) valid[idx] = 1'b0;
         if (n == chg_n) begin
            cmd[idx] = c2; addr[idx] = a2; data[idx] = d2;
         end
         prev = line;
      end
   endtask

   initial begin
      rst = 3'b000;
      valid = 3'b000;
      for (int i = 0; i < 3; i++) begin
         cmd[i] = 8'h00; addr[i] = 16'h0000; data[i] = 32'h0;
      end

      // Reset asserted mid-cycle: outputs go to reset values without a clock
      #2 rst = 3'b111;
      #1;
      chk("rst_uart_tx", txl[0], 1);
      chk("rst_tx_busy", busy[0], 0);
      chk("rst_pkt_done", done[0], 0);
      chk("rst_resp_ready", ready[0], 0);
      #99 rst = 3'b000;
      #1;
      chk("rst_ready_before_edge", ready, 3'b000);
      @(posedge clk);
      #1;
      chk("rst_ready_after_edge", ready, 3'b111);
      @(negedge clk);

      // Status reply at default rate
      start_pkt(0, 8'h70, 16'h0000, 32'h0000_0001);
      capture(0, 434, 31250, 1, 0, 8'h00, 16'h0000, 32'h0);
      chk_bytes("st", exp_st);
      chk("st_first_start", qat(got_s, 0), 1);
      chk("st_byte6_start", qat(got_s, 6), 26041);
      chk("st_bit_edges", bad_edge, 0);
      chk("st_frame_bits", bad_stop, 0);
      chk("st_done_count", done_q.size(), 1);
      chk("st_done_cycle", qat(done_q, 0), 31248);
      chk("st_busy_fall", busy_lo, 31248);

      // Bit timing, 10 clocks per bit
      start_pkt(1, 8'hA5, 16'h5A3C, 32'hDEAD_BEEF);
      capture(1, 10, 725, 1, 0, 8'h00, 16'h0000, 32'h0);
      chk_bytes("bt", exp_a5);
      for (int k = 0; k < 7; k++)
         chk($sformatf("bt_start%0d", k), qat(got_s, k), 1 + 100 * k);
      chk("bt_bit_edges", bad_edge, 0);
      chk("bt_frame_bits", bad_stop, 0);
      chk("bt_done_cycle", qat(done_q, 0), 720);

      // Back-to-back with valid held; inputs change mid-packet
      start_pkt(1, 8'h70, 16'h0001, 32'h1122_3344);
      capture(1, 10, 1445, 721, 50, 8'h00, 16'h0008, 32'h0000_0008);
      chk_bytes("bb", exp_bb);
      chk("bb_pkt2_start", qat(got_s, 7), 721);
      chk("bb_pkt2_last_start", qat(got_s, 13), 1321);
      chk("bb_done_count", done_q.size(), 2);
      chk("bb_done1", qat(done_q, 0), 720);
      chk("bb_done2", qat(done_q, 1), 1440);
      chk("bb_busy_fall", busy_lo, 720);
      chk("bb_bit_edges", bad_edge, 0);

      // Reset during byte 3 (data byte 0 = 0x00, line low)
      start_pkt(1, 8'h70, 16'hFFFF, 32'h0000_0000);
      capture(1, 10, 335, 1, 0, 8'h00, 16'h0000, 32'h0);
      chk("rm_line_low_before", txl[1], 0);
      #2 rst[1] = 1'b1;
      #1;
      chk("rm_uart_tx", txl[1], 1);
      chk("rm_tx_busy", busy[1], 0);
      chk("rm_pkt_done", done[1], 0);
      repeat (3) @(negedge clk);
      rst[1] = 1'b0;
      @(negedge clk);
      capture(1, 10, 800, 0, 0, 8'h00, 16'h0000, 32'h0);
      chk("rm_no_bytes", got_b.size(), 0);
      chk("rm_no_done", done_q.size(), 0);
      start_pkt(1, 8'h50, 16'h1234, 32'hCAFE_F00D);
      capture(1, 10, 725, 1, 0, 8'h00, 16'h0000, 32'h0);
      chk_bytes("rm", exp_cf);
      chk("rm_done_cycle", qat(done_q, 0), 720);

      // Small config, no gap: packets butt together
      start_pkt(2, 8'h30, 16'h0102, 32'h0304_0506);
      capture(2, 8, 1125, 561, 40, 8'h20, 16'hFFFF, 32'h8000_0001);
      chk_bytes("sm", exp_sm);
      chk("sm_done1", qat(done_q, 0), 560);
      chk("sm_done2", qat(done_q, 1), 1120);
      chk("sm_pkt2_start", qat(got_s, 7), 561);
      chk("sm_bit_edges", bad_edge, 0);
      chk("sm_frame_bits", bad_stop, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
